// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, glyph codes and the BCD decoder.
// Segments are active-high with bit 0 = a through bit 6 = g.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  // Non-BCD codes 10..15 show a dash so a corrupt digit is visible, not silently blank.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] bcd);
    logic [SEG_W-1:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder for the currently scanned digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: latches NDIG BCD digits and swaps the shown value
// only at frame boundaries so a frame never mixes old and new digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] digit_in,
  input  logic              load,
  input  logic              blank,
  output logic [SEG_W-1:0]  seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [PW-1:0]       ps_q, ps_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   stage_q, stage_d;
  logic [4*NDIG-1:0]   disp_q, disp_d;
  logic                pend_q, pend_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic                fd_q, fd_d;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_dig;
  logic [SEG_W-1:0]    cur_seg;
  logic [NDIG-1:0]     lz_mask;

  assign tick    = (ps_q == PS_LAST);
  assign wrap    = tick && (idx_q == IDX_LAST);
  assign cur_dig = disp_q[4*int'(idx_q) +: 4];

  seg7_decode u_decode (
    .bcd_i (cur_dig),
    .seg_o (cur_seg)
  );

  // A digit is a leading zero when it and every more-significant digit are zero;
  // codes 10..15 count as nonzero. Digit 0 always shows.
  always_comb begin
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'd0);
      lz_mask[k] = (BLANK_LZ != 0) && (k > 0) && upper_zero;
    end
  end

  always_comb begin
    ps_d    = tick ? '0 : ps_q + 1'b1;
    idx_d   = idx_q;
    stage_d = stage_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    seg_d   = SEG_OFF;
    an_d    = '0;
    fd_d    = wrap;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // A load landing on the wrap edge bypasses staging and shows in the new frame.
    if (wrap && load) begin
      disp_d  = digit_in;
      stage_d = digit_in;
      pend_d  = 1'b0;
    end else begin
      if (wrap && pend_q) begin
        disp_d = stage_q;
        pend_d = 1'b0;
      end
      if (load) begin
        stage_d = digit_in;
        pend_d  = 1'b1;
      end
    end

    if (!blank) begin
      an_d  = NDIG'(1) << idx_q;
      seg_d = lz_mask[idx_q] ? SEG_OFF : cur_seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q    <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      disp_q  <= '0;
      pend_q  <= 1'b0;
      seg_q   <= '0;
      an_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (NDIG=4, PRESCALE=4, BLANK_LZ=1).
// Expectations are keyed by edge count since reset release; a monitor compares them.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digit_in = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         n;
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    bit         is_fd;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NDIG(4), .PRESCALE(4), .BLANK_LZ(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_in   (digit_in),
    .load       (load),
    .blank      (blank),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  task automatic push(input int n, input logic [6:0] s, input logic [3:0] a,
                      input logic f, input bit isf);
    exp_t e;
    int   i;
    e.n = n; e.seg = s; e.an = a; e.fd = f; e.is_fd = isf;
    i = q.size();
    while (i > 0 && q[i-1].n > n) i--;
    q.insert(i, e);
  endtask

  // First and last cycle of every slot in frame f, plus the frame_done pulse edges.
  task automatic exp_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      push(16*f + 4*k + 1, s[k], 4'(1 << k), 1'b0, 1'b0);
      push(16*f + 4*k + 4, s[k], 4'(1 << k), 1'b0, 1'b0);
    end
    push(16*f + 15, '0, '0, 1'b0, 1'b1);
    push(16*f + 16, '0, '0, 1'b1, 1'b1);
    push(16*f + 17, '0, '0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      while (q.size() > 0 && q[0].n <= cyc) begin
        e = q.pop_front();
        if (e.n != cyc) chk("edge_alignment", e.n, cyc, e.n);
        if (e.is_fd) begin
          chk("frame_done", e.n, frame_done, e.fd);
        end else begin
          chk("seg", e.n, seg, e.seg);
          chk("an", e.n, an, e.an);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) chk("wait_cyc_timeout", n, cyc, n);
  endtask

  task automatic do_load(input int n, input logic [15:0] v);
    wait_cyc(n);
    digit_in = v;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_seg", 0, seg, 7'h00);
    chk("reset_an", 0, an, 4'h0);
    chk("reset_frame_done", 0, frame_done, 1'b0);

    // Phase 1: free scan of an all-zero display, then reset mid-slot.
    exp_frame(0, 7'h3F, 7'h00, 7'h00, 7'h00);
    exp_frame(1, 7'h3F, 7'h00, 7'h00, 7'h00);
    reset = 1'b1;
    do_load(33, 16'h0888);
    wait_cyc(34);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_seg", 34, seg, 7'h00);
    chk("async_reset_an", 34, an, 4'h0);
    chk("async_reset_frame_done", 34, frame_done, 1'b0);
    chk("phase1_drained", 34, q.size(), 0);
    repeat (2) @(negedge clk);

    // Phase 2: the staged 0888 must have been discarded by reset.
    exp_frame(0, 7'h3F, 7'h00, 7'h00, 7'h00);
    exp_frame(1, 7'h3F, 7'h00, 7'h00, 7'h00);
    exp_frame(2, 7'h07, 7'h3F, 7'h6F, 7'h00);
    exp_frame(3, 7'h3F, 7'h00, 7'h00, 7'h00);
    exp_frame(4, 7'h6D, 7'h40, 7'h00, 7'h00);
    exp_frame(5, 7'h5B, 7'h5B, 7'h5B, 7'h5B);
    exp_frame(6, 7'h4F, 7'h4F, 7'h4F, 7'h4F);
    push(113, 7'h4F, 4'b0001, 1'b0, 1'b0);
    push(115, 7'h4F, 4'b0001, 1'b0, 1'b0);
    push(116, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(118, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(121, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(122, 7'h4F, 4'b0100, 1'b0, 1'b0);
    push(125, 7'h4F, 4'b1000, 1'b0, 1'b0);
    push(128, 7'h4F, 4'b1000, 1'b0, 1'b0);
    push(120, '0, '0, 1'b0, 1'b1);
    push(128, '0, '0, 1'b1, 1'b1);
    push(129, '0, '0, 1'b0, 1'b1);
    push(130, 7'h4F, 4'b0001, 1'b0, 1'b0);
    reset = 1'b1;

    do_load(20, 16'h0907);
    do_load(36, 16'h0000);
    do_load(52, 16'h00C5);
    do_load(68, 16'h1111);
    do_load(72, 16'h2222);
    do_load(95, 16'h3333);
    wait_cyc(115);
    blank = 1'b1;
    wait_cyc(121);
    blank = 1'b0;
    wait_cyc(135);
    chk("scoreboard_drained", 135, q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
